// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between fetch and load/store
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, RESP} state_t;
    state_t state, state_nx;
    logic last_d, own_d, i_win, d_win;
    logic [3:0] cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // on a tie the requester not granted last wins
    assign i_win = i_req && (!d_req || last_d);
    assign d_win = d_req && !i_win;
    assign i_gnt = !reset && state == IDLE && i_win;
    assign d_gnt = !reset && state == IDLE && d_win;
    assign mem_addr = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wr = state == WRITE;
    assign i_rvalid = state == RESP && !own_d;
    assign d_done = state == WRITE || (state == RESP && own_d);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (d_win && d_we) ? WRITE : (i_win || d_win) ? RD_WAIT : IDLE;
            WRITE:   state_nx = IDLE;
            RD_WAIT: state_nx = cnt == 4'd1 ? RESP : RD_WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last_d <= 1'b1;
            own_d <= 1'b0;
            cnt <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (i_win || d_win)) begin
                last_d <= d_win;
                own_d <= d_win;
                addr_q <= d_win ? d_addr : i_addr;
                cnt <= 4'(RD_LAT);
            end
            if (state == IDLE && d_win)
                wdata_q <= d_wdata;
            if (state == RD_WAIT)
                cnt <= cnt - 4'd1;
            if (state == RD_WAIT && cnt == 4'd1)
                rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed requests checked each cycle against a transaction-level model
module tb_mem_port_arbiter;
    localparam int LAT = 2;
    logic clock = 0, reset = 1;
    logic i_req = 0, d_req = 0, d_we = 0;
    logic [63:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic i_gnt, d_gnt, i_rvalid, d_done, mem_wr;
    logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic d_req1 = 0;
    logic [63:0] d_addr1 = 0;
    logic i_gnt1, d_gnt1, i_rvalid1, d_done1, mem_wr1;
    logic [63:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic [63:0] mem [64];
    int checks = 0, errors = 0, cyc = 0;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(LAT)) dut (
        .clock(clock), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .rdata(rdata), .mem_addr(mem_addr), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .i_req(1'b0), .i_addr(64'd0), .i_gnt(i_gnt1),
        .i_rvalid(i_rvalid1), .d_req(d_req1), .d_we(1'b0), .d_addr(d_addr1), .d_wdata(64'd0),
        .d_gnt(d_gnt1), .d_done(d_done1), .rdata(rdata1), .mem_addr(mem_addr1), .mem_wr(mem_wr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1));

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr[8:3]];
    assign mem_rdata1 = mem[mem_addr1[8:3]];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 64'h0123_4567_0000_0000 | (64'(i) * 64'h101);
        mem[8] = 64'h13;
        forever begin
            @(posedge clock);
            if (mem_wr) mem[mem_addr[8:3]] <= mem_wdata;
        end
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    // requester agents: raise req for the head of the queue, drop it the cycle after a grant
    typedef struct { logic we; logic [63:0] a; logic [63:0] w; } dreq_t;
    logic [63:0] i_q [$];
    dreq_t d_q [$];
    logic ig_s, dg_s;
    initial forever begin
        @(negedge clock);
        ig_s = i_gnt;
        dg_s = d_gnt;
        @(posedge clock);
        #1;
        if (ig_s) begin void'(i_q.pop_front()); i_req = 0; end
        else if (i_q.size() > 0) begin i_req = 1; i_addr = i_q[0]; end
        if (dg_s) begin void'(d_q.pop_front()); d_req = 0; end
        else if (d_q.size() > 0) begin d_req = 1; d_we = d_q[0].we; d_addr = d_q[0].a; d_wdata = d_q[0].w; end
    end

    // model: m_t counts cycles since the grant of the transaction in flight (0 = idle)
    int m_t = 0;
    logic m_last_d = 1, m_own_d = 0, m_we = 0;
    logic [63:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    logic gi, gd, ewr, eirv, edd;
    int g_cyc = 0, p_cyc = 0, dd_cnt = 0;
    logic ord [$];

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            m_t = 0; m_last_d = 1; m_own_d = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
        end
        gi = !reset && m_t == 0 && i_req && (!d_req || m_last_d);
        gd = !reset && m_t == 0 && d_req && !gi;
        ewr = m_t == 1 && m_we;
        eirv = m_t == LAT + 1 && !m_we && !m_own_d;
        edd = ewr || (m_t == LAT + 1 && !m_we && m_own_d);
        chk("i_gnt", i_gnt, gi);
        chk("d_gnt", d_gnt, gd);
        chk("mem_wr", mem_wr, ewr);
        chk("i_rvalid", i_rvalid, eirv);
        chk("d_done", d_done, edd);
        chk("mem_addr", mem_addr, m_addr);
        chk("rdata", rdata, m_rdata);
        if (ewr) chk("mem_wdata", mem_wdata, m_wdata);
        if (i_gnt || d_gnt) begin g_cyc = cyc; ord.push_back(d_gnt); end
        if (i_rvalid || d_done) p_cyc = cyc;
        if (d_done) dd_cnt++;
        if (gi || gd) begin
            m_t = 1; m_last_d = gd; m_own_d = gd; m_we = gd && d_we;
            m_addr = gd ? d_addr : i_addr;
            if (gd) m_wdata = d_wdata;
        end else if (ewr || m_t == LAT + 1) m_t = 0;
        else if (m_t > 0) begin
            if (m_t == LAT) m_rdata = mem[m_addr[8:3]];
            m_t++;
        end
    end

    task automatic wait_idle();
        int k = 0;
        do begin @(negedge clock); k++; end
        while (k < 200 && !(i_q.size() == 0 && d_q.size() == 0 && !i_req && !d_req && m_t == 0 && !i_rvalid && !d_done));
        chk("idle_timeout", 64'(k < 200), 1);
        @(negedge clock);
    endtask

    initial begin
        int k, dd_before;
        repeat (2) @(negedge clock);
        @(posedge clock); #1 reset = 0;
        // late address change on the RD_LAT=1 instance
        @(negedge clock);
        d_addr1 = 64'h8; d_req1 = 1;
        #1 chk("late_gnt", d_gnt1, 1);
        @(posedge clock); #1 d_req1 = 0; d_addr1 = 64'h10;
        @(negedge clock);
        chk("late_addr_c1", mem_addr1, 64'h8);
        chk("late_done_c1", d_done1, 0);
        @(negedge clock);
        chk("late_done_c2", d_done1, 1);
        chk("late_rdata", rdata1, 64'h0123_4567_0000_0101);
        chk("late_addr_c2", mem_addr1, 64'h8);
        chk("late_irv", i_rvalid1, 0);
        // fetch read
        i_q.push_back(64'h40);
        wait_idle();
        chk("fetch_rdata", rdata, 64'h13);
        chk("fetch_lat", 64'(p_cyc - g_cyc), 3);
        // store
        d_q.push_back('{1'b1, 64'h100, 64'hDEAD_BEEF_CAFE_F00D});
        wait_idle();
        chk("store_lat", 64'(p_cyc - g_cyc), 1);
        chk("store_rdata_hold", rdata, 64'h13);
        chk("store_mem", mem[32], 64'hDEAD_BEEF_CAFE_F00D);
        // round robin under continuous contention
        ord.delete();
        i_q.push_back(64'h48); i_q.push_back(64'h50);
        d_q.push_back('{1'b0, 64'h58, 64'h0}); d_q.push_back('{1'b0, 64'h60, 64'h0});
        wait_idle();
        chk("rr_count", 64'(ord.size()), 4);
        chk("rr_order", {ord[0], ord[1], ord[2], ord[3]}, 4'b0101);
        chk("rr_rdata", rdata, 64'h0123_4567_0000_0C0C);
        ord.delete();
        d_q.push_back('{1'b0, 64'h68, 64'h0}); d_q.push_back('{1'b0, 64'h70, 64'h0});
        wait_idle();
        chk("lone_d_count", 64'(ord.size()), 2);
        chk("lone_d_order", {ord[0], ord[1]}, 2'b11);
        // reset with both requests pending
        @(negedge clock);
        i_q.push_back(64'h28); d_q.push_back('{1'b0, 64'h30, 64'h0});
        @(posedge clock); #3 reset = 1;
        #1 chk("rst_outs", {i_gnt, d_gnt, i_rvalid, d_done, mem_wr}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", mem_addr, 0);
        repeat (2) @(negedge clock);
        @(posedge clock); #1 reset = 0;
        @(negedge clock);
        chk("tie_i_gnt", i_gnt, 1);
        chk("tie_d_gnt", d_gnt, 0);
        wait_idle();
        // abort a load in RD_WAIT
        d_q.push_back('{1'b0, 64'h18, 64'h0});
        k = 0;
        while (!d_gnt && k < 20) begin @(negedge clock); k++; end
        chk("abort_gnt_seen", 64'(k < 20), 1);
        @(negedge clock);
        dd_before = dd_cnt;
        #1 reset = 1;
        #1 chk("abort_outs", {i_gnt, d_gnt, i_rvalid, d_done, mem_wr}, 0);
        chk("abort_addr", mem_addr, 0);
        repeat (2) @(negedge clock);
        @(posedge clock); #1 reset = 0;
        repeat (6) @(negedge clock);
        chk("abort_no_done", 64'(dd_cnt), 64'(dd_before));
        i_q.push_back(64'h20);
        wait_idle();
        chk("post_abort_rdata", rdata, 64'h0123_4567_0000_0404);
        chk("post_abort_lat", 64'(p_cyc - g_cyc), 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
